// File: rtl/cache_memory_burst.sv
// Cache data array with byte-enabled core access and a block burst engine.
// N_WORDS_PER_BLOCK banks of N_BLOCKS words each, 1-cycle registered read.
// The burst engine fills a block from, or drains a block to, the memory side
// one word per valid/ready handshake.
// Optional macro CACHE_MEMORY_BURST_PARITY_EN: stores one even-parity bit per
// byte and adds the parity_err_o output.
module cache_memory_burst #(
  parameter int BW_DATA           = 32,
  parameter int N_BLOCKS          = 128,
  parameter int N_WORDS_PER_BLOCK = 4,
  localparam int BW_ADDR   = $clog2(N_BLOCKS),
  localparam int BW_OFFSET = $clog2(N_WORDS_PER_BLOCK),
  localparam int N_BYTES   = BW_DATA / 8
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 core_req_i,
  input  logic                 core_wren_i,
  input  logic [N_BYTES-1:0]   core_byte_en_i,
  input  logic [BW_ADDR-1:0]   core_addr_i,
  input  logic [BW_OFFSET-1:0] core_offset_i,
  input  logic [BW_DATA-1:0]   core_data_i,
  output logic [BW_DATA-1:0]   core_data_o,
  output logic                 core_ack_o,
  output logic                 busy_o,
  input  logic                 fill_start_i,
  input  logic                 drain_start_i,
  input  logic [BW_ADDR-1:0]   burst_addr_i,
  input  logic [BW_DATA-1:0]   fill_data_i,
  input  logic                 fill_valid_i,
  output logic                 fill_ready_o,
  output logic [BW_DATA-1:0]   drain_data_o,
  output logic                 drain_valid_o,
  input  logic                 drain_ready_i,
`ifdef CACHE_MEMORY_BURST_PARITY_EN
  output logic                 parity_err_o,
`endif
  output logic                 burst_done_o
);

`ifdef CACHE_MEMORY_BURST_PARITY_EN
  localparam int BANK_W = BW_DATA + N_BYTES;
`else
  localparam int BANK_W = BW_DATA;
`endif

  typedef enum logic [2:0] {IDLE, FILL, DRAIN_RD, DRAIN_WAIT, DONE} state_t;

  state_t                 state_q, state_d;
  logic [BW_OFFSET-1:0]   counter_q;
  logic [BW_ADDR-1:0]     burst_addr_q;
  logic                   busy_q;
  logic                   ack_q;
  logic [BW_DATA-1:0]     core_data_q;
  logic [BW_DATA-1:0]     drain_data_q;

  logic [BANK_W-1:0]      mem [N_WORDS_PER_BLOCK][N_BLOCKS];

  logic                   core_accept;
  logic                   last_word;
  logic                   wr_en;
  logic [BW_OFFSET-1:0]   wr_bank;
  logic [BW_ADDR-1:0]     wr_addr;
  logic [BW_DATA-1:0]     wr_data;
  logic [N_BYTES-1:0]     wr_be;
  logic [BANK_W-1:0]      core_rd_word;
  logic [BANK_W-1:0]      drain_rd_word;

  // Core access only wins when the engine is idle and no burst is starting.
  assign core_accept = (state_q == IDLE) && core_req_i && !fill_start_i && !drain_start_i;
  assign last_word   = (counter_q == BW_OFFSET'(N_WORDS_PER_BLOCK - 1));

  assign core_rd_word  = mem[core_offset_i][core_addr_i];
  assign drain_rd_word = mem[counter_q][burst_addr_q];

  assign core_ack_o    = ack_q;
  assign busy_o        = busy_q;
  assign core_data_o   = core_data_q;
  assign drain_data_o  = drain_data_q;
  assign fill_ready_o  = (state_q == FILL);
  assign drain_valid_o = (state_q == DRAIN_WAIT);
  assign burst_done_o  = (state_q == DONE);

`ifdef CACHE_MEMORY_BURST_PARITY_EN
  logic core_perr_q;
  logic drain_perr_q;

  function automatic logic parity_bad(input logic [BANK_W-1:0] w);
    logic bad;
    bad = 1'b0;
    for (int b = 0; b < N_BYTES; b++) begin
      bad = bad | (^{w[BW_DATA + b], w[b*8 +: 8]});
    end
    return bad;
  endfunction

  assign parity_err_o = (ack_q && core_perr_q) || ((state_q == DRAIN_WAIT) && drain_perr_q);

  // Parity status travels with the read data it was computed from.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      core_perr_q  <= 1'b0;
      drain_perr_q <= 1'b0;
    end else begin
      if (core_accept) core_perr_q <= !core_wren_i && parity_bad(core_rd_word);
      if (state_q == DRAIN_RD) drain_perr_q <= parity_bad(drain_rd_word);
    end
  end
`endif

  // State register; busy is registered from the next state so it lines up with it.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == FILL) || (state_d == DRAIN_RD) || (state_d == DRAIN_WAIT);
    end
  end

  // Next-state logic; fill has priority over drain when both start together.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (fill_start_i)       state_d = FILL;
        else if (drain_start_i) state_d = DRAIN_RD;
      end
      FILL:       if (fill_valid_i && last_word) state_d = DONE;
      DRAIN_RD:   state_d = DRAIN_WAIT;
      DRAIN_WAIT: if (drain_ready_i) state_d = last_word ? DONE : DRAIN_RD;
      DONE:       state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Burst bookkeeping: latch the block on start, step the word counter per handshake.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      counter_q    <= '0;
      burst_addr_q <= '0;
    end else begin
      if (state_q == IDLE && (fill_start_i || drain_start_i)) begin
        counter_q    <= '0;
        burst_addr_q <= burst_addr_i;
      end else if ((state_q == FILL && fill_valid_i) || (state_q == DRAIN_WAIT && drain_ready_i)) begin
        if (!last_word) counter_q <= counter_q + BW_OFFSET'(1);
      end
    end
  end

  // Single write port shared by core writes and fill words; never both at once.
  always_comb begin
    wr_en   = 1'b0;
    wr_bank = core_offset_i;
    wr_addr = core_addr_i;
    wr_data = core_data_i;
    wr_be   = core_byte_en_i;
    if (core_accept && core_wren_i) begin
      wr_en = !reset_i;
    end else if (state_q == FILL && fill_valid_i) begin
      wr_en   = !reset_i;
      wr_bank = counter_q;
      wr_addr = burst_addr_q;
      wr_data = fill_data_i;
      wr_be   = '1;
    end
  end

  // Array storage, written byte by byte; contents survive reset.
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      for (int b = 0; b < N_BYTES; b++) begin
        if (wr_be[b]) begin
          mem[wr_bank][wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
`ifdef CACHE_MEMORY_BURST_PARITY_EN
          mem[wr_bank][wr_addr][BW_DATA + b] <= ^wr_data[b*8 +: 8];
`endif
        end
      end
    end
  end

  // Read registers and the core ack; core data holds until the next read.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      ack_q        <= 1'b0;
      core_data_q  <= '0;
      drain_data_q <= '0;
    end else begin
      ack_q <= core_accept;
      if (core_accept && !core_wren_i) core_data_q <= core_rd_word[BW_DATA-1:0];
      if (state_q == DRAIN_RD) drain_data_q <= drain_rd_word[BW_DATA-1:0];
    end
  end

endmodule

// File: tb/tb_cache_memory_burst.sv
// Scoreboard bench for cache_memory_burst: stimulus pushes expected core
// acks and drained words into queues, a negedge monitor pops and compares.
// Build with CACHE_MEMORY_BURST_PARITY_EN to also exercise parity_err_o.
module tb_cache_memory_burst;

  logic        clock_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        core_req_i = 1'b0;
  logic        core_wren_i = 1'b0;
  logic [3:0]  core_byte_en_i = '0;
  logic [6:0]  core_addr_i = '0;
  logic [1:0]  core_offset_i = '0;
  logic [31:0] core_data_i = '0;
  logic [31:0] core_data_o;
  logic        core_ack_o;
  logic        busy_o;
  logic        fill_start_i = 1'b0;
  logic        drain_start_i = 1'b0;
  logic [6:0]  burst_addr_i = '0;
  logic [31:0] fill_data_i = '0;
  logic        fill_valid_i = 1'b0;
  logic        fill_ready_o;
  logic [31:0] drain_data_o;
  logic        drain_valid_o;
  logic        drain_ready_i = 1'b0;
  logic        burst_done_o;
`ifdef CACHE_MEMORY_BURST_PARITY_EN
  logic        parity_err_o;
`endif

  cache_memory_burst dut (
    .clock_i(clock_i), .reset_i(reset_i),
    .core_req_i(core_req_i), .core_wren_i(core_wren_i),
    .core_byte_en_i(core_byte_en_i), .core_addr_i(core_addr_i),
    .core_offset_i(core_offset_i), .core_data_i(core_data_i),
    .core_data_o(core_data_o), .core_ack_o(core_ack_o), .busy_o(busy_o),
    .fill_start_i(fill_start_i), .drain_start_i(drain_start_i),
    .burst_addr_i(burst_addr_i), .fill_data_i(fill_data_i),
    .fill_valid_i(fill_valid_i), .fill_ready_o(fill_ready_o),
    .drain_data_o(drain_data_o), .drain_valid_o(drain_valid_o),
    .drain_ready_i(drain_ready_i),
`ifdef CACHE_MEMORY_BURST_PARITY_EN
    .parity_err_o(parity_err_o),
`endif
    .burst_done_o(burst_done_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    logic        perr;
  } core_exp_t;

  core_exp_t   core_q[$];
  logic [31:0] drain_q[$];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  int          done_cnt = 0;
  int          fill_ready_cnt = 0;
  logic [31:0] last_read = '0;

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clock_i);
    #1;
  endtask

  task automatic do_reset();
    reset_i = 1'b1;
    step();
    step();
    reset_i = 1'b0;
    last_read = '0;
  endtask

  // One core access; the ack expectation is queued at issue time.
  task automatic apply_stimulus(input logic wr, input logic [3:0] be, input logic [6:0] addr,
                                input logic [1:0] off, input logic [31:0] wdata,
                                input logic [31:0] exp_rd, input logic exp_perr);
    core_exp_t e;
    core_req_i = 1'b1;
    core_wren_i = wr;
    core_byte_en_i = be;
    core_addr_i = addr;
    core_offset_i = off;
    core_data_i = wdata;
    e.cyc = cyc + 1;
    if (wr) begin
      e.data = last_read;
      e.perr = 1'b0;
    end else begin
      e.data = exp_rd;
      e.perr = exp_perr;
      last_read = exp_rd;
    end
    core_q.push_back(e);
    step();
    core_req_i = 1'b0;
    core_wren_i = 1'b0;
    step();
  endtask

  task automatic wait_done(input int budget);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget && done_cnt == start; i++) step();
    check_output("burst_done_count", 32'(done_cnt), 32'(start + 1));
  endtask

  // Monitor: compares every DUT presentation against the queued expectations.
  always @(negedge clock_i) begin
    core_exp_t e;
    if (fill_ready_o) fill_ready_cnt++;
    if (burst_done_o) begin
      done_cnt++;
      check_output("busy_in_done", 32'(busy_o), 32'd0);
    end
    if (core_ack_o) begin
      if (core_q.size() == 0) begin
        check_output("unexpected_ack", 32'(core_ack_o), 32'd0);
      end else begin
        e = core_q.pop_front();
        check_output("core_data", core_data_o, e.data);
        check_output("ack_cycle", 32'(cyc), 32'(e.cyc));
`ifdef CACHE_MEMORY_BURST_PARITY_EN
        check_output("parity_err", 32'(parity_err_o), 32'(e.perr));
`endif
      end
    end
    if (drain_valid_o) begin
      if (drain_q.size() == 0) begin
        check_output("unexpected_drain", 32'(drain_valid_o), 32'd0);
      end else begin
        check_output("drain_data", drain_data_o, drain_q[0]);
        if (drain_ready_i) void'(drain_q.pop_front());
      end
    end
  end

  initial begin
    logic pat [4];
    int   d0;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    do_reset();
    check_output("rst_busy", 32'(busy_o), 32'd0);
    check_output("rst_ack", 32'(core_ack_o), 32'd0);
    check_output("rst_fill_ready", 32'(fill_ready_o), 32'd0);
    check_output("rst_drain_valid", 32'(drain_valid_o), 32'd0);
    check_output("rst_done", 32'(burst_done_o), 32'd0);
    check_output("rst_core_data", core_data_o, 32'd0);
    check_output("rst_drain_data", drain_data_o, 32'd0);

    // Fill block 5 with A0..A3, valid held high.
    $display("[TB] fill block 5");
    fill_ready_cnt = 0;
    burst_addr_i = 7'd5;
    fill_start_i = 1'b1;
    step();
    fill_start_i = 1'b0;
    check_output("busy_in_fill", 32'(busy_o), 32'd1);
    for (int i = 0; i < 4; i++) begin
      fill_valid_i = 1'b1;
      fill_data_i = 32'hA0 + 32'(i);
      step();
    end
    fill_valid_i = 1'b0;
    wait_done(6);
    check_output("fill_ready_cycles", 32'(fill_ready_cnt), 32'd4);
    check_output("busy_after_fill", 32'(busy_o), 32'd0);

    for (int i = 0; i < 4; i++)
      apply_stimulus(1'b0, 4'h0, 7'd5, 2'(i), 32'h0, 32'hA0 + 32'(i), 1'b0);

    // Byte-enabled write over 0x000000A2.
    $display("[TB] byte write");
    apply_stimulus(1'b1, 4'b0101, 7'd5, 2'd2, 32'hDEADBEEF, 32'h0, 1'b0);
    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd2, 32'h0, 32'h00AD00EF, 1'b0);

    // Drain block 5 with ready toggling to force stalls.
    $display("[TB] drain block 5");
    drain_q.push_back(32'hA0);
    drain_q.push_back(32'hA1);
    drain_q.push_back(32'h00AD00EF);
    drain_q.push_back(32'hA3);
    d0 = done_cnt;
    burst_addr_i = 7'd5;
    drain_start_i = 1'b1;
    step();
    drain_start_i = 1'b0;
    for (int i = 0; i < 40 && done_cnt == d0; i++) begin
      drain_ready_i = pat[i % 4];
      step();
    end
    drain_ready_i = 1'b0;
    check_output("drain_done_count", 32'(done_cnt), 32'(d0 + 1));
    check_output("drain_words_left", 32'(drain_q.size()), 32'd0);

    // All three requests at once: fill wins, core and drain are dropped.
    $display("[TB] start collision then reset mid-fill");
    d0 = done_cnt;
    burst_addr_i = 7'd5;
    fill_start_i = 1'b1;
    drain_start_i = 1'b1;
    core_req_i = 1'b1;
    core_offset_i = 2'd0;
    core_addr_i = 7'd5;
    step();
    fill_start_i = 1'b0;
    drain_start_i = 1'b0;
    core_req_i = 1'b0;
    check_output("collision_fill_ready", 32'(fill_ready_o), 32'd1);
    check_output("collision_drain_valid", 32'(drain_valid_o), 32'd0);
    fill_valid_i = 1'b1;
    fill_data_i = 32'hB0;
    step();
    fill_data_i = 32'hB1;
    step();
    fill_valid_i = 1'b0;
    reset_i = 1'b1;
    step();
    reset_i = 1'b0;
    last_read = '0;
    check_output("reset_busy", 32'(busy_o), 32'd0);
    check_output("reset_fill_ready", 32'(fill_ready_o), 32'd0);
    step();
    check_output("reset_no_done", 32'(done_cnt), 32'(d0));

    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd0, 32'h0, 32'hB0, 1'b0);
    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd1, 32'h0, 32'hB1, 1'b0);
    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd2, 32'h0, 32'h00AD00EF, 1'b0);
    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd3, 32'h0, 32'hA3, 1'b0);

`ifdef CACHE_MEMORY_BURST_PARITY_EN
    $display("[TB] parity corruption");
    dut.mem[0][5][0] = ~dut.mem[0][5][0];
    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd0, 32'h0, 32'hB1, 1'b1);
    apply_stimulus(1'b0, 4'h0, 7'd5, 2'd1, 32'h0, 32'hB1, 1'b0);
`endif

    step();
    step();
    check_output("core_acks_left", 32'(core_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cache_memory_burst.md
Name: cache_memory_burst

Overview:
- Next-generation cache data array: N_WORDS_PER_BLOCK word banks, each N_BLOCKS deep, with 1-cycle synchronous read.
- Adds byte-enabled core word access, plus a burst engine that fills a block from, or drains a block to, the memory-side controller one word at a time over valid/ready handshakes.
- Sits between the cache controller (core port) and the miss/writeback path (burst ports).

Parameters:
- BW_DATA, 32, word width in bits; must be a multiple of 8.
- N_BLOCKS, 128, blocks in the array; power of two.
- N_WORDS_PER_BLOCK, 4, words per block; power of two, >=2.
- Derived: BW_ADDR=CLOG2(N_BLOCKS), BW_OFFSET=CLOG2(N_WORDS_PER_BLOCK), N_BYTES=BW_DATA/8.

Ports:
- clock_i  in  1  single clock; all logic is rising-edge.
- reset_i  in  1  synchronous, active-high reset.
- core_req_i  in  1  core access request.
- core_wren_i  in  1  1=write, 0=read.
- core_byte_en_i  in  N_BYTES  byte lanes to write; ignored on reads.
- core_addr_i  in  BW_ADDR  block address.
- core_offset_i  in  BW_OFFSET  word within the block.
- core_data_i  in  BW_DATA  write data.
- core_data_o  out  BW_DATA  read data; meaningful when core_ack_o=1 for a read.
- core_ack_o  out  1  1-cycle pulse, one cycle after an accepted request.
- busy_o  out  1  registered; 1 while a burst is in progress.
- fill_start_i  in  1  start a block fill.
- drain_start_i  in  1  start a block drain.
- burst_addr_i  in  BW_ADDR  target block; sampled at start.
- fill_data_i  in  BW_DATA  fill word.
- fill_valid_i  in  1  fill word valid.
- fill_ready_o  out  1  engine accepts a fill word.
- drain_data_o  out  BW_DATA  drained word.
- drain_valid_o  out  1  drained word valid.
- drain_ready_i  in  1  consumer accepts the drained word.
- burst_done_o  out  1  1-cycle pulse after the last word of a burst.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; word counter 0. Memory contents are not cleared.
- FSM states: IDLE, FILL, DRAIN_RD, DRAIN_WAIT, DONE.
- IDLE:
  - fill_start_i goes to FILL.
  - drain_start_i goes to DRAIN_RD.
  - If both are asserted, fill wins.
  - Starts latch burst_addr_i and clear the counter.
- Core accept rule: a core request is accepted only in IDLE with neither start asserted. Requests at any other time are dropped, with no ack.
- Core write: bytes whose core_byte_en_i bit is set are written at (addr, offset) on the accept edge; all other bytes and words are unchanged. core_ack_o pulses on the next cycle.
- Core read: core_data_o holds bank[offset][addr] in the ack cycle and holds its value until the next read ack.
- FILL:
  - fill_ready_o=1.
  - On fill_valid_i & fill_ready_o, the full word is written to word[counter] of the latched block and the counter increments.
  - After word N_WORDS_PER_BLOCK-1 is written, go to DONE.
  - fill_valid_i low stalls the engine indefinitely.
- DRAIN_RD: issue a read of word[counter]; go to DRAIN_WAIT next cycle.
- DRAIN_WAIT:
  - drain_valid_o=1; drain_data_o is registered and stable while valid and not ready.
  - On drain_ready_i, the counter increments and the FSM goes to DRAIN_RD, or to DONE after the last word.
  - Throughput is one word per 2 cycles.
- DONE: burst_done_o=1 for one cycle, then IDLE. busy_o=0 in the DONE cycle.
- busy_o=1 in FILL, DRAIN_RD and DRAIN_WAIT.
- Counter: BW_OFFSET bits, compared to N_WORDS_PER_BLOCK-1; it never wraps within a burst.
- Start pulses arriving while the FSM is not in IDLE are ignored.
- Reset mid-burst: the FSM returns to IDLE; there is no burst_done_o; words already filled remain written.

Optional Feature:
- Macro CACHE_MEMORY_BURST_PARITY_EN.
- Defined:
  - Each bank stores one even-parity bit per byte, so bank width is BW_DATA+N_BYTES.
  - Parity bits are written with each written byte.
  - Added output parity_err_o (1 bit) is asserted with core_ack_o on reads, and with drain_valid_o, if any byte's parity mismatches; otherwise 0. Reset value 0.
- Undefined: no parity storage and no parity_err_o port.

Test Plan:
- Reset, then fill block 5 with words 0xA0..0xA3 (valid always high) -> fill_ready_o=1 for 4 cycles; burst_done_o pulses once; core reads of block 5, offsets 0..3, return 0xA0..0xA3 with core_ack_o one cycle after each req.
- Core write 0xDEADBEEF to block 5 offset 2 with byte_en=4'b0101 over 0xA2 -> read returns 0x00AD00EF. Hmm: the bytes that are not enabled keep the old word 0x000000A2, so the read returns 0x00AD00EF.
- Drain block 5 with drain_ready_i toggling 1,0,0,1 -> drain_data_o stable during stalls; sequence 0xA0, 0xA1, 0x00AD00EF, 0xA3; then burst_done_o pulses.
- fill_start_i, drain_start_i and core_req_i all in the same cycle -> FILL entered; no core_ack_o; drain never starts.
- reset_i asserted after 2 fill words -> IDLE next cycle; busy_o=0; no burst_done_o; words 0-1 updated, words 2-3 unchanged.
- CACHE_MEMORY_BURST_PARITY_EN: force-flip a stored data bit of block 5 word 0 -> parity_err_o=1 on the read ack; a clean word gives 0.
